store_rmw_unit: RTL and testbench
=================================

Name: store_rmw_unit

Overview:
- Sequential store-merge engine between the datapath store path and a word-wide data memory port.
- Accepts one store request (byte / halfword / word / doubleword) and performs the memory-side read-modify-write.
- Full-width stores skip the read. Partial stores read the containing word, replace only the addressed byte lanes, and write the merged word back.
- Generalises the byte-only store merge to XLEN-wide words, all store sizes and a handshaked memory interface.

Parameters:
- XLEN, 32: data word width in bits. Must be 32 or 64.
- ADDR_W, 32: byte-address width.
- NB, XLEN/8: byte lanes per word (derived).
- OFF_W, log2(NB): byte-offset bits (derived).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready
- req_addr  in  ADDR_W  byte address of the store
- req_wdata  in  XLEN  store data, right-aligned (bits [8*n-1:0] used)
- req_size  in  2  00 byte, 01 half, 10 word(32), 11 dword (64; treated as 10 when XLEN=32)
- done  out  1  one-cycle pulse: store committed
- misalign_err  out  1  one-cycle pulse: store rejected (MISALIGN_TRAP_EN only; else constant 0)
- mem_addr  out  ADDR_W  word-aligned address (low OFF_W bits 0)
- mem_rd_en  out  1  read strobe
- mem_rd_valid  in  1  read data valid
- mem_rd_data  in  XLEN  read data
- mem_wr_en  out  1  write request, held until acked
- mem_wr_data  out  XLEN  merged write word
- mem_wr_ack  in  1  write accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; only reset is used.
- Reset values: state=IDLE, req_ready=1, done=0, misalign_err=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
- Reset mid-operation: abandons the transaction on the next edge; no write is issued after reset.
- Store size: n = 1<<size bytes, clamped to NB.
- Offset: off = req_addr[OFF_W-1:0]. Without the feature, off is aligned down to a multiple of n.
- Lane mask: lane k written iff off <= k < off+n.
- Merged lane k = req_wdata byte (k-off) if masked, else mem_rd_data byte k.
- States: IDLE, READ, WAIT_RD, WRITE, DONE.
  - IDLE: req_ready=1. On accept, latch addr/data/size/mask; mem_addr <= aligned addr. If n==NB go to WRITE with mem_wr_data=req_wdata; else go to READ.
  - READ: mem_rd_en=1 for exactly one cycle; go to WAIT_RD.
  - WAIT_RD: wait for mem_rd_valid. On it, register the merged word into mem_wr_data and go to WRITE. mem_rd_valid arriving in the READ cycle is ignored (memory latency >= 1).
  - WRITE: mem_wr_en=1 and mem_wr_data stable until mem_wr_ack; ack in the same cycle as first assertion is legal. On ack go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
- req_ready is 0 in every state except IDLE; a new request is never accepted in the DONE cycle.
- Minimum latency, accept edge to done pulse:
  - full-width store with immediate ack: 2 cycles.
  - partial store with 1-cycle read and immediate ack: 4 cycles.
- mem_rd_data is sampled only in WAIT_RD while mem_rd_valid=1. Stray valid/ack in other states is ignored.
- Memory ordering: one transaction in flight; no write-to-read forwarding required.

Optional Feature:
- Macro: STORE_RMW_MISALIGN_TRAP_EN.
- Defined: a request whose off is not a multiple of n is accepted, no memory access occurs, misalign_err pulses 1 cycle in the cycle after accept, and the unit returns to IDLE. done stays 0 for that request.
- Undefined: misalign_err is tied to 0 and the offset is aligned down as above; all requests complete normally.

Test Plan:
- XLEN=32: sb addr 0x103, wdata 0x000000AB, mem returns 0x11223344 -> mem_addr 0x100, mem_wr_data 0xAB223344, done once, mem_rd_en pulsed once.
- XLEN=32: sh addr 0x102, wdata 0x0000BEEF, mem returns 0x11223344 -> mem_wr_data 0xBEEF3344. sw addr 0x200, wdata 0xDEADBEEF -> no mem_rd_en, write 0xDEADBEEF, done 2 cycles after accept.
- XLEN=64: sw addr 0x0C, wdata 0xCAFEF00D, mem returns 0x0011223344556677 -> mem_addr 0x08, mem_wr_data 0xCAFEF00D44556677.
- Backpressure: mem_rd_valid delayed 3 cycles, mem_wr_ack delayed 2 cycles -> mem_wr_en/mem_wr_data stable throughout, req_ready=0 until after done, second queued req_valid accepted only in IDLE.
- Reset asserted in WAIT_RD -> next edge all outputs at reset values, no mem_wr_en ever asserted, req_ready=1.
- With STORE_RMW_MISALIGN_TRAP_EN: sh addr 0x101 -> misalign_err one pulse, no mem_rd_en/mem_wr_en, done=0. Without it: same request writes lanes 0-1 (addr aligned to 0x100).

Source files
------------

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: sequential store merge that turns byte/half/word/dword stores into word-wide memory RMW.
// Optional STORE_RMW_MISALIGN_TRAP_EN: misaligned stores are rejected with misalign_err instead of aligned down.
module store_rmw_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic              mem_rd_valid,
    input  logic [XLEN-1:0]   mem_rd_data,
    output logic              mem_wr_en,
    output logic [XLEN-1:0]   mem_wr_data,
    input  logic              mem_wr_ack
);
    localparam int NB = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [1:0] MAX_SZ = 2'(OFF_W);
    localparam logic [OFF_W-1:0] ONE_OFF = OFF_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            state_q;
    logic              req_ready_q;
    logic              done_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wr_data_q;
    logic [XLEN-1:0]   wdata_q;
    logic [NB-1:0]     mask_q;

    logic [1:0]        size_s;
    logic [OFF_W-1:0]  szmask_s;
    logic [OFF_W-1:0]  raw_off_s;
    logic [OFF_W-1:0]  off_s;
    logic              full_s;
    logic [NB-1:0]     mask_s;
    logic [XLEN-1:0]   wdata_sh_s;
    logic [XLEN-1:0]   merged_s;

    // Decode size/offset into a lane mask; the modular shift makes szmask all-ones for full-width stores.
    always_comb begin
        size_s     = (req_size > MAX_SZ) ? MAX_SZ : req_size;
        szmask_s   = (ONE_OFF << size_s) - ONE_OFF;
        raw_off_s  = req_addr[OFF_W-1:0];
        off_s      = raw_off_s & ~szmask_s;
        full_s     = (size_s == MAX_SZ);
        wdata_sh_s = req_wdata << {off_s, 3'b000};
        mask_s     = {NB{1'b0}};
        for (int k = 0; k < NB; k++) begin
            mask_s[k] = (k >= int'(off_s)) && (k < int'(off_s) + int'(szmask_s) + 1);
        end
    end

    // Lane-wise merge of the latched store data over the word read back from memory.
    always_comb begin
        merged_s = {XLEN{1'b0}};
        for (int k = 0; k < NB; k++) begin
            merged_s[8*k +: 8] = mask_q[k] ? wdata_q[8*k +: 8] : mem_rd_data[8*k +: 8];
        end
    end

`ifdef STORE_RMW_MISALIGN_TRAP_EN
    logic misalign_s;
    logic err_q;
    assign misalign_s = ((raw_off_s & szmask_s) != {OFF_W{1'b0}});
    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

    // Transaction FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wr_data_q   <= {XLEN{1'b0}};
            wdata_q     <= {XLEN{1'b0}};
            mask_q      <= {NB{1'b0}};
`ifdef STORE_RMW_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
`ifdef STORE_RMW_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mask_q      <= mask_s;
                        wdata_q     <= wdata_sh_s;
`ifdef STORE_RMW_MISALIGN_TRAP_EN
                        if (misalign_s) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else
`endif
                        if (full_s) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= req_wdata;
                            state_q   <= ST_WRITE;
                        end else begin
                            rd_en_q <= 1'b1;
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    state_q <= ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    if (mem_rd_valid) begin
                        wr_data_q <= merged_s;
                        wr_en_q   <= 1'b1;
                        state_q   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (mem_wr_ack) begin
                        wr_en_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    wr_en_q     <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign done        = done_q;
    assign mem_addr    = addr_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit: directed and random stores on a 32-bit and a 64-bit instance,
// compared against a byte-lane reference model of the store-merge rules.
`timescale 1ns/1ps
module tb_store_rmw_unit;
`ifdef STORE_RMW_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        sel64 = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_rd_valid = 1'b0;
    logic        mem_wr_ack = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [63:0] req_wdata = 64'h0;
    logic [63:0] mem_rd_data = 64'h0;
    logic [1:0]  req_size = 2'b00;

    logic        v32, v64, rv32, rv64, ack32, ack64;
    logic        r32_ready, r32_done, r32_err, r32_rd_en, r32_wr_en;
    logic        r64_ready, r64_done, r64_err, r64_rd_en, r64_wr_en;
    logic [31:0] r32_addr, r64_addr, r32_wr_data;
    logic [63:0] r64_wr_data;

    assign v32   = req_valid & ~sel64;
    assign v64   = req_valid & sel64;
    assign rv32  = mem_rd_valid & ~sel64;
    assign rv64  = mem_rd_valid & sel64;
    assign ack32 = mem_wr_ack & ~sel64;
    assign ack64 = mem_wr_ack & sel64;

    store_rmw_unit #(.XLEN(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .reset(reset), .req_valid(v32), .req_ready(r32_ready), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .req_size(req_size), .done(r32_done), .misalign_err(r32_err),
        .mem_addr(r32_addr), .mem_rd_en(r32_rd_en), .mem_rd_valid(rv32), .mem_rd_data(mem_rd_data[31:0]),
        .mem_wr_en(r32_wr_en), .mem_wr_data(r32_wr_data), .mem_wr_ack(ack32)
    );

    store_rmw_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .reset(reset), .req_valid(v64), .req_ready(r64_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .done(r64_done), .misalign_err(r64_err),
        .mem_addr(r64_addr), .mem_rd_en(r64_rd_en), .mem_rd_valid(rv64), .mem_rd_data(mem_rd_data),
        .mem_wr_en(r64_wr_en), .mem_wr_data(r64_wr_data), .mem_wr_ack(ack64)
    );

    logic        o_ready, o_done, o_err, o_rd_en, o_wr_en;
    logic [31:0] o_addr;
    logic [63:0] o_wr_data;
    assign o_ready   = sel64 ? r64_ready : r32_ready;
    assign o_done    = sel64 ? r64_done  : r32_done;
    assign o_err     = sel64 ? r64_err   : r32_err;
    assign o_rd_en   = sel64 ? r64_rd_en : r32_rd_en;
    assign o_wr_en   = sel64 ? r64_wr_en : r32_wr_en;
    assign o_addr    = sel64 ? r64_addr  : r32_addr;
    assign o_wr_data = sel64 ? r64_wr_data : {32'h0, r32_wr_data};

    int n_pass = 0;
    int n_total = 0;

    logic [63:0] obs_wr_word;
    logic [31:0] obs_wr_addr, obs_rd_addr;
    int          obs_rd_cnt, obs_wr_cnt, obs_done_cnt, obs_err_cnt, obs_done_lat;
    logic        obs_stable, obs_timeout, obs_early_ready, obs_ready_at_start;

    // Reference: n = min(1<<size, nb) bytes, offset aligned down to n, store bytes replace lanes off..off+n-1.
    function automatic logic [63:0] model_merge(input int nb, input logic [31:0] addr, input logic [63:0] wdata,
                                                input logic [1:0] size, input logic [63:0] old);
        int n, off;
        logic [63:0] res;
        n = 1 << size;
        if (n > nb) n = nb;
        off = int'(addr[2:0]) % nb;
        off = off - (off % n);
        res = old;
        if (nb == 4) res[63:32] = 32'h0;
        for (int b = 0; b < n; b++) res[8*(off+b) +: 8] = wdata[8*b +: 8];
        return res;
    endfunction

    // Presents one store and plays the memory side with the given read/ack delays, recording what it sees.
    task automatic run_store(input logic [31:0] addr, input logic [63:0] wdata, input logic [1:0] size,
                             input logic [63:0] old, input int rd_dly, input int ack_dly, input logic hold_next,
                             input logic [31:0] n_addr, input logic [63:0] n_wdata, input logic [1:0] n_size);
        int rd_timer, lat;
        obs_wr_word = 64'h0; obs_wr_addr = 32'h0; obs_rd_addr = 32'h0;
        obs_rd_cnt = 0; obs_wr_cnt = 0; obs_done_cnt = 0; obs_err_cnt = 0; obs_done_lat = 0;
        obs_stable = 1'b1; obs_timeout = 1'b1; obs_early_ready = 1'b0;
        obs_ready_at_start = o_ready;
        req_addr = addr; req_wdata = wdata; req_size = size; req_valid = 1'b1;
        @(posedge clk); #1;
        if (hold_next) begin
            req_addr = n_addr; req_wdata = n_wdata; req_size = n_size;
        end else begin
            req_valid = 1'b0;
        end
        rd_timer = 0;
        lat = 1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            mem_rd_valid = 1'b0;
            mem_wr_ack = 1'b0;
            mem_rd_data = {$urandom, $urandom};
            if (o_ready) begin
                obs_timeout = 1'b0;
                obs_early_ready = (obs_done_cnt == 0) && (obs_err_cnt == 0);
                break;
            end
            if (o_done) begin obs_done_cnt++; obs_done_lat = lat; end
            if (o_err) obs_err_cnt++;
            if (o_rd_en) begin
                obs_rd_cnt++;
                obs_rd_addr = o_addr;
                rd_timer = rd_dly;
                mem_rd_valid = 1'b1;
                mem_wr_ack = 1'b1;
            end else if (rd_timer > 0) begin
                rd_timer--;
                if (rd_timer == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data = old;
                end
            end
            if (o_wr_en) begin
                if (obs_wr_cnt == 0) begin
                    obs_wr_word = o_wr_data;
                    obs_wr_addr = o_addr;
                end else if (o_wr_data !== obs_wr_word || o_addr !== obs_wr_addr) begin
                    obs_stable = 1'b0;
                end
                if (obs_wr_cnt == ack_dly) mem_wr_ack = 1'b1;
                obs_wr_cnt++;
            end
            @(posedge clk); #1;
            lat++;
        end
        mem_rd_valid = 1'b0;
        mem_wr_ack = 1'b0;
    endtask

    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            sel64 = s[0];
            #1;
            n_total++;
            if ({o_ready, o_done, o_err, o_rd_en, o_wr_en} !== 5'b10000 || o_addr !== 32'h0 || o_wr_data !== 64'h0)
                $display("FAIL reset_values dut%0d: rdy/done/err/rd/wr=%b addr=%h wdata=%h, required 10000 0 0",
                         s, {o_ready, o_done, o_err, o_rd_en, o_wr_en}, o_addr, o_wr_data);
            else n_pass++;
        end
        sel64 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed32;
        sel64 = 1'b0; #1;
        run_store(32'h103, 64'hAB, 2'b00, 64'h11223344, 1, 0, 1'b0, 32'h0, 64'h0, 2'b00);
        n_total++;
        if (obs_wr_word !== 64'hAB223344 || obs_wr_addr !== 32'h100 || obs_rd_addr !== 32'h100)
            $display("FAIL sb_merge: word=%h addr=%h rdaddr=%h, required AB223344 100 100", obs_wr_word, obs_wr_addr, obs_rd_addr);
        else n_pass++;
        n_total++;
        if (obs_rd_cnt !== 1 || obs_done_cnt !== 1 || obs_done_lat !== 4)
            $display("FAIL sb_timing: rd=%0d done=%0d lat=%0d, required 1 1 4", obs_rd_cnt, obs_done_cnt, obs_done_lat);
        else n_pass++;
        run_store(32'h102, 64'hBEEF, 2'b01, 64'h11223344, 1, 0, 1'b0, 32'h0, 64'h0, 2'b00);
        n_total++;
        if (obs_wr_word !== 64'hBEEF3344)
            $display("FAIL sh_merge: word=%h, required BEEF3344", obs_wr_word);
        else n_pass++;
        run_store(32'h200, 64'hDEADBEEF, 2'b10, 64'h55555555, 1, 0, 1'b0, 32'h0, 64'h0, 2'b00);
        n_total++;
        if (obs_rd_cnt !== 0 || obs_wr_word !== 64'hDEADBEEF || obs_done_lat !== 2 || obs_done_cnt !== 1)
            $display("FAIL sw_full: rd=%0d word=%h lat=%0d done=%0d, required 0 DEADBEEF 2 1",
                     obs_rd_cnt, obs_wr_word, obs_done_lat, obs_done_cnt);
        else n_pass++;
        run_store(32'h204, 64'h0123456789ABCDEF, 2'b11, 64'h0, 1, 0, 1'b0, 32'h0, 64'h0, 2'b00);
        n_total++;
        if (obs_rd_cnt !== 0 || obs_wr_word !== 64'h89ABCDEF || obs_wr_addr !== 32'h204)
            $display("FAIL sd_clamp32: rd=%0d word=%h addr=%h, required 0 89ABCDEF 204", obs_rd_cnt, obs_wr_word, obs_wr_addr);
        else n_pass++;
    endtask

    task automatic test_xlen64;
        sel64 = 1'b1; #1;
        run_store(32'h0C, 64'hCAFEF00D, 2'b10, 64'h0011223344556677, 1, 0, 1'b0, 32'h0, 64'h0, 2'b00);
        n_total++;
        if (obs_wr_word !== 64'hCAFEF00D44556677 || obs_wr_addr !== 32'h08 || obs_rd_cnt !== 1 || obs_done_lat !== 4)
            $display("FAIL sw_on_64: word=%h addr=%h rd=%0d lat=%0d, required CAFEF00D44556677 8 1 4",
                     obs_wr_word, obs_wr_addr, obs_rd_cnt, obs_done_lat);
        else n_pass++;
        run_store(32'h18, 64'hFEDCBA9876543210, 2'b11, 64'h0, 1, 1, 1'b0, 32'h0, 64'h0, 2'b00);
        n_total++;
        if (obs_wr_word !== 64'hFEDCBA9876543210 || obs_rd_cnt !== 0 || obs_done_lat !== 3)
            $display("FAIL sd_on_64: word=%h rd=%0d lat=%0d, required FEDCBA9876543210 0 3", obs_wr_word, obs_rd_cnt, obs_done_lat);
        else n_pass++;
        sel64 = 1'b0; #1;
    endtask

    task automatic test_back_to_back;
        logic [63:0] old;
        sel64 = 1'b0; #1;
        old = {32'h0, $urandom};
        run_store(32'h301, 64'h5A, 2'b00, old, 3, 2, 1'b1, 32'h400, 64'h12345678, 2'b10);
        n_total++;
        if (!obs_stable || obs_wr_cnt !== 3 || obs_early_ready || obs_timeout)
            $display("FAIL backpressure_hold: stable=%b wr_cycles=%0d early_ready=%b timeout=%b, required 1 3 0 0",
                     obs_stable, obs_wr_cnt, obs_early_ready, obs_timeout);
        else n_pass++;
        n_total++;
        if (obs_done_lat !== 8 || obs_wr_word !== {old[63:16], 8'h5A, old[7:0]} || obs_done_cnt !== 1)
            $display("FAIL backpressure_data: lat=%0d word=%h done=%0d, required 8 %h 1",
                     obs_done_lat, obs_wr_word, obs_done_cnt, {old[63:16], 8'h5A, old[7:0]});
        else n_pass++;
        run_store(32'h400, 64'h12345678, 2'b10, 64'h0, 1, 0, 1'b0, 32'h0, 64'h0, 2'b00);
        n_total++;
        if (!obs_ready_at_start || obs_wr_word !== 64'h12345678 || obs_wr_addr !== 32'h400 || obs_done_cnt !== 1)
            $display("FAIL queued_second: ready=%b word=%h addr=%h done=%0d, required 1 12345678 400 1",
                     obs_ready_at_start, obs_wr_word, obs_wr_addr, obs_done_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int bad;
        sel64 = 1'b0; #1;
        req_addr = 32'h501; req_wdata = 64'h77; req_size = 2'b00; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_total++;
        if (o_rd_en !== 1'b1) $display("FAIL mid_reset_read: rd_en=%b, required 1", o_rd_en);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_total++;
        if ({o_ready, o_done, o_err, o_rd_en, o_wr_en} !== 5'b10000 || o_addr !== 32'h0 || o_wr_data !== 64'h0)
            $display("FAIL mid_reset_values: rdy/done/err/rd/wr=%b addr=%h wdata=%h, required 10000 0 0",
                     {o_ready, o_done, o_err, o_rd_en, o_wr_en}, o_addr, o_wr_data);
        else n_pass++;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            mem_rd_valid = 1'b1; mem_wr_ack = c[0]; mem_rd_data = {$urandom, $urandom};
            @(posedge clk); #1;
            if (o_wr_en !== 1'b0 || o_ready !== 1'b1 || o_done !== 1'b0) bad++;
        end
        mem_rd_valid = 1'b0; mem_wr_ack = 1'b0;
        n_total++;
        if (bad !== 0) $display("FAIL mid_reset_quiet: bad_cycles=%0d, required 0", bad);
        else n_pass++;
    endtask

    task automatic test_misalign;
        sel64 = 1'b0; #1;
        run_store(32'h101, 64'hBEEF, 2'b01, 64'h11223344, 1, 0, 1'b0, 32'h0, 64'h0, 2'b00);
`ifdef STORE_RMW_MISALIGN_TRAP_EN
        n_total++;
        if (obs_err_cnt !== 1 || obs_done_cnt !== 0 || obs_rd_cnt !== 0 || obs_wr_cnt !== 0 || obs_timeout)
            $display("FAIL misalign_trap: err=%0d done=%0d rd=%0d wr=%0d timeout=%b, required 1 0 0 0 0",
                     obs_err_cnt, obs_done_cnt, obs_rd_cnt, obs_wr_cnt, obs_timeout);
        else n_pass++;
`else
        n_total++;
        if (obs_wr_word !== 64'h1122BEEF || obs_wr_addr !== 32'h100 || obs_err_cnt !== 0 || obs_done_cnt !== 1)
            $display("FAIL misalign_aligned: word=%h addr=%h err=%0d done=%0d, required 1122BEEF 100 0 1",
                     obs_wr_word, obs_wr_addr, obs_err_cnt, obs_done_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_random;
        logic [31:0] addr, exp_addr;
        logic [63:0] wd, old, exp_w;
        logic [1:0]  sz;
        int nb, n, rd, ack, off, exp_lat;
        bit mis, trap;
        for (int it = 0; it < 48; it++) begin
            sel64 = 1'($urandom_range(0, 1));
            #1;
            nb = sel64 ? 8 : 4;
            addr = 32'($urandom_range(0, 65535));
            wd = {$urandom, $urandom};
            old = {$urandom, $urandom};
            if (!sel64) old[63:32] = 32'h0;
            sz = 2'($urandom_range(0, 3));
            rd = int'($urandom_range(1, 4));
            ack = int'($urandom_range(0, 3));
            n = 1 << sz;
            if (n > nb) n = nb;
            off = int'(addr[2:0]) % nb;
            mis = (off % n) != 0;
            trap = TRAP && mis;
            exp_w = model_merge(nb, addr, wd, sz, old);
            exp_addr = addr & ~(32'(nb) - 32'd1);
            exp_lat = (n == nb) ? (2 + ack) : (3 + rd + ack);
            run_store(addr, wd, sz, old, rd, ack, 1'b0, 32'h0, 64'h0, 2'b00);
            n_total++;
            if (obs_timeout || !obs_ready_at_start || obs_early_ready)
                $display("FAIL rand_handshake it=%0d: timeout=%b ready_start=%b early=%b, required 0 1 0",
                         it, obs_timeout, obs_ready_at_start, obs_early_ready);
            else n_pass++;
            if (trap) begin
                n_total++;
                if (obs_err_cnt !== 1 || obs_done_cnt !== 0 || obs_rd_cnt !== 0 || obs_wr_cnt !== 0)
                    $display("FAIL rand_trap it=%0d: err=%0d done=%0d rd=%0d wr=%0d, required 1 0 0 0",
                             it, obs_err_cnt, obs_done_cnt, obs_rd_cnt, obs_wr_cnt);
                else n_pass++;
            end else begin
                n_total++;
                if (obs_wr_word !== exp_w || obs_wr_addr !== exp_addr)
                    $display("FAIL rand_data it=%0d: word=%h addr=%h, required %h %h", it, obs_wr_word, obs_wr_addr, exp_w, exp_addr);
                else n_pass++;
                n_total++;
                if (obs_done_cnt !== 1 || obs_err_cnt !== 0 || obs_rd_cnt !== ((n == nb) ? 0 : 1) || obs_done_lat !== exp_lat)
                    $display("FAIL rand_flow it=%0d: done=%0d err=%0d rd=%0d lat=%0d, required 1 0 %0d %0d",
                             it, obs_done_cnt, obs_err_cnt, obs_rd_cnt, obs_done_lat, (n == nb) ? 0 : 1, exp_lat);
                else n_pass++;
                n_total++;
                if (!obs_stable || obs_wr_cnt !== ack + 1)
                    $display("FAIL rand_write_hold it=%0d: stable=%b wr_cycles=%0d, required 1 %0d", it, obs_stable, obs_wr_cnt, ack + 1);
                else n_pass++;
            end
        end
        sel64 = 1'b0; #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        reset = 1'b0;
        @(posedge clk); #1;
        test_directed32;
        test_xlen64;
        test_back_to_back;
        test_reset_mid;
        test_misalign;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
